// File: rtl/ad9643_regmap_pkg.sv
// Shared types and default geometry for the AD9643 staged register map.
package ad9643_regmap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        CLEAR
    } fsm_t;

    localparam int unsigned XFER_BIT = 0;
    localparam int unsigned SRST_BIT = 5;

    localparam int unsigned DEF_ADDR_W    = 8;
    localparam int unsigned DEF_DATA_W    = 8;
    localparam logic [7:0]  DEF_BUF_LO    = 8'h08;
    localparam logic [7:0]  DEF_BUF_HI    = 8'hFE;
    localparam logic [7:0]  DEF_XFER_ADDR = 8'hFF;
    localparam logic [7:0]  DEF_SRST_ADDR = 8'h00;

endpackage

// File: rtl/ad9643_seq_ptr.sv
// Sequencing pointer shared by the copy and clear walks: loadable, free-running
// increment, with terminal and skip-address flags.
module ad9643_seq_ptr #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              adv,
    input  logic [ADDR_W-1:0] term_val,
    input  logic [ADDR_W-1:0] skip_addr,
    output logic [ADDR_W-1:0] ptr,
    output logic              last,
    output logic              skip
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (load)     ptr_d = load_val;
        else if (adv) ptr_d = ptr_q + ADDR_W'(1);
    end

    assign ptr  = ptr_q;
    assign last = (ptr_q == term_val);
    assign skip = (ptr_q == skip_addr);

endmodule

// File: rtl/ad9643_regmap_xfer.sv
// AD9643 register map: direct bank plus double-buffered staging/active bank,
// with sequenced staging-to-active transfer and sequenced soft-reset clear.
module ad9643_regmap_xfer
    import ad9643_regmap_pkg::*;
#(
    parameter int unsigned       ADDR_W    = DEF_ADDR_W,
    parameter int unsigned       DATA_W    = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] BUF_LO    = ADDR_W'(DEF_BUF_LO),
    parameter logic [ADDR_W-1:0] BUF_HI    = ADDR_W'(DEF_BUF_HI),
    parameter logic [ADDR_W-1:0] XFER_ADDR = ADDR_W'(DEF_XFER_ADDR),
    parameter logic [ADDR_W-1:0] SRST_ADDR = ADDR_W'(DEF_SRST_ADDR)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            wr_en,
    output logic                            wr_ready,
    input  logic [ADDR_W-1:0]               addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            rd_sel,
    output logic [DATA_W-1:0]               rd_data,
    output logic [DATA_W*(2**ADDR_W)-1:0]   active,
    output logic                            busy,
    output logic                            xfer_done
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    fsm_t state_q, state_d;

    // regs_q is stage[] inside the buffered range and dir[] everywhere else.
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] act_q  [DEPTH];
    logic [DATA_W-1:0] act_d  [DEPTH];
    logic              xfer_done_q, xfer_done_d;

    logic              wr_fire, in_buf, copy_trig, srst_trig;
    logic              ptr_load, ptr_adv, ptr_last, ptr_skip;
    logic [ADDR_W-1:0] ptr_load_val, ptr_term, ptr;

    assign wr_fire   = wr_en && wr_ready;
    assign in_buf    = (addr >= BUF_LO) && (addr <= BUF_HI);
    assign copy_trig = wr_fire && (addr == XFER_ADDR) && wr_data[XFER_BIT];
    assign srst_trig = wr_fire && (addr == SRST_ADDR) && wr_data[SRST_BIT];

    assign ptr_load     = copy_trig || srst_trig;
    assign ptr_load_val = copy_trig ? BUF_LO : '0;

    ad9643_seq_ptr #(
        .ADDR_W (ADDR_W)
    ) u_seq_ptr (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (ptr_load),
        .load_val  (ptr_load_val),
        .adv       (ptr_adv),
        .term_val  (ptr_term),
        .skip_addr (SRST_ADDR),
        .ptr       (ptr),
        .last      (ptr_last),
        .skip      (ptr_skip)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (copy_trig)      state_d = COPY;
                else if (srst_trig) state_d = CLEAR;
            end
            COPY, CLEAR: if (ptr_last) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
        ptr_adv  = (state_q != IDLE);
        ptr_term = (state_q == COPY) ? BUF_HI : '1;
    end

    always_comb begin
        regs_d      = regs_q;
        act_d       = act_q;
        xfer_done_d = 1'b0;
        if (wr_fire) regs_d[addr] = wr_data;
        unique case (state_q)
            COPY: begin
                act_d[ptr] = regs_q[ptr];
                if (ptr_last) begin
                    regs_d[XFER_ADDR][XFER_BIT] = 1'b0;
                    xfer_done_d                 = 1'b1;
                end
            end
            CLEAR: begin
                if (!ptr_skip) begin
                    regs_d[ptr] = '0;
                    act_d[ptr]  = '0;
                end
                if (ptr_last) regs_d[SRST_ADDR][SRST_BIT] = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xfer_done_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
                act_q[i]  <= '0;
            end
        end else begin
            xfer_done_q <= xfer_done_d;
            regs_q      <= regs_d;
            act_q       <= act_d;
        end
    end

    assign xfer_done = xfer_done_q;

    always_comb begin
        if (in_buf && rd_sel) rd_data = act_q[addr];
        else                  rd_data = regs_q[addr];
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_active
        if (g >= 32'(BUF_LO) && g <= 32'(BUF_HI)) begin : g_buf
            assign active[g*DATA_W +: DATA_W] = act_q[g];
        end else begin : g_dir
            assign active[g*DATA_W +: DATA_W] = regs_q[g];
        end
    end

endmodule

// File: tb/tb_ad9643_regmap_xfer.sv
// Self-checking bench: a per-cycle reference model of the register map for the
// default instance, plus directed literal checks on both parameter sets.
module tb_ad9643_regmap_xfer;

    localparam int BLO = 8'h08;
    localparam int BHI = 8'hFE;
    localparam int XF  = 8'hFF;
    localparam int SR  = 8'h00;

    logic          clk = 1'b0;
    logic          reset_n, wr_en, rd_sel, wr_ready, busy, xfer_done;
    logic [7:0]    addr, wr_data, rd_data;
    logic [2047:0] active;

    logic          s_reset_n, s_wr_en, s_rd_sel, s_wr_ready, s_busy, s_xfer_done;
    logic [3:0]    s_addr;
    logic [7:0]    s_wr_data, s_rd_data;
    logic [127:0]  s_active;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ad9643_regmap_xfer dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_ready(wr_ready),
        .addr(addr), .wr_data(wr_data), .rd_sel(rd_sel), .rd_data(rd_data),
        .active(active), .busy(busy), .xfer_done(xfer_done)
    );

    ad9643_regmap_xfer #(
        .ADDR_W(4), .DATA_W(8), .BUF_LO(4'h5), .BUF_HI(4'h5),
        .XFER_ADDR(4'hF), .SRST_ADDR(4'h0)
    ) dut_small (
        .clk(clk), .reset_n(s_reset_n), .wr_en(s_wr_en), .wr_ready(s_wr_ready),
        .addr(s_addr), .wr_data(s_wr_data), .rd_sel(s_rd_sel), .rd_data(s_rd_data),
        .active(s_active), .busy(s_busy), .xfer_done(s_xfer_done)
    );

    // Reference model: separate stage/act/dir images, sequence tracked by step count.
    logic [7:0] m_stage [256];
    logic [7:0] m_act   [256];
    logic [7:0] m_dir   [256];
    int         m_mode;   // 0 none, 1 copy, 2 clear
    int         m_k;
    logic       m_done;

    function automatic logic m_in_buf(int a);
        return (a >= BLO) && (a <= BHI);
    endfunction

    function automatic logic [7:0] m_read(int a, logic s);
        if (m_in_buf(a)) return s ? m_act[a] : m_stage[a];
        return m_dir[a];
    endfunction

    function automatic logic [2047:0] m_active();
        logic [2047:0] v;
        for (int i = 0; i < 256; i++) v[i*8 +: 8] = m_in_buf(i) ? m_act[i] : m_dir[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
            m_stage[i] = 8'h00; m_act[i] = 8'h00; m_dir[i] = 8'h00;
        end
        m_mode = 0; m_k = 0; m_done = 1'b0;
    endtask

    task automatic model_step();
        int a;
        m_done = 1'b0;
        if (m_mode == 1) begin
            a = BLO + m_k;
            m_act[a] = m_stage[a];
            m_k++;
            if (a == BHI) begin
                m_dir[XF][0] = 1'b0; m_done = 1'b1; m_mode = 0;
            end
        end else if (m_mode == 2) begin
            if (m_k != SR) begin
                m_stage[m_k] = 8'h00; m_act[m_k] = 8'h00; m_dir[m_k] = 8'h00;
            end
            if (m_k == 255) begin
                m_dir[SR][5] = 1'b0; m_mode = 0;
            end
            m_k++;
        end else if (wr_en) begin
            if (m_in_buf(int'(addr))) m_stage[addr] = wr_data;
            else                      m_dir[addr]   = wr_data;
            if (int'(addr) == XF && wr_data[0]) begin
                m_mode = 1; m_k = 0;
            end else if (int'(addr) == SR && wr_data[5]) begin
                m_mode = 2; m_k = 0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_active();
        logic [2047:0] e;
        int first;
        e = m_active();
        n_cmp++;
        if (active !== e) begin
            n_bad++;
            first = 0;
            for (int i = 255; i >= 0; i--) if (active[i*8 +: 8] !== e[i*8 +: 8]) first = i;
            $display("FAIL active[%0d]: got %0h expected %0h (t=%0t)",
                     first, active[first*8 +: 8], e[first*8 +: 8], $time);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("m_busy",      busy,      32'(m_mode != 0));
            check("m_wr_ready",  wr_ready,  32'(m_mode == 0));
            check("m_xfer_done", xfer_done, 32'(m_done));
            check("m_rd_data",   rd_data,   32'(m_read(int'(addr), rd_sel)));
            check_active();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        addr = a; wr_data = d; wr_en = 1'b1;
        while (!wr_ready && n < 1000) begin
            tick();
            n++;
        end
        check("wr_accept_wait", 32'(n >= 1000), 0);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        check("wait_idle", busy, 0);
    endtask

    int cyc, pulses;

    initial begin
        reset_n = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0; rd_sel = 1'b0;
        s_reset_n = 1'b0; s_wr_en = 1'b0; s_addr = '0; s_wr_data = '0; s_rd_sel = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", xfer_done, 0);
        check("rst_rd", rd_data, 0);
        reset_n = 1'b1; s_reset_n = 1'b1;
        tick();
        check("rst_ready", wr_ready, 1);

        // staging write is not visible in the active view
        do_write(8'h10, 8'h3C);
        addr = 8'h10; rd_sel = 1'b0; #1;
        check("stage10", rd_data, 8'h3C);
        rd_sel = 1'b1; #1;
        check("act10_pre", rd_data, 8'h00);
        check("active16_pre", active[16*8 +: 8], 8'h00);
        rd_sel = 1'b0;

        // full transfer
        do_write(8'hFF, 8'h01);
        cyc = 0; pulses = 0;
        while (busy && cyc < 1000) begin
            tick();
            cyc++;
            if (xfer_done) pulses++;
        end
        tick();
        if (xfer_done) pulses++;
        check("copy_cycles", cyc, 247);
        check("copy_pulses", pulses, 1);
        check("active16_post", active[16*8 +: 8], 8'h3C);
        addr = 8'hFF; #1;
        check("xfer_bit_clr", rd_data, 8'h00);

        // write held off during COPY lands in staging only
        do_write(8'h20, 8'h11);
        addr = 8'hFF; wr_data = 8'h01; wr_en = 1'b1;
        tick();
        addr = 8'h20; wr_data = 8'h55; rd_sel = 1'b0;
        repeat (10) tick();
        check("blk_stage", rd_data, 8'h11);
        rd_sel = 1'b1; #1;
        check("blk_act_mid", rd_data, 8'h00);
        rd_sel = 1'b0;
        cyc = 0;
        while (!wr_ready && cyc < 1000) begin
            tick();
            cyc++;
        end
        tick();
        wr_en = 1'b0;
        #1;
        check("blk_stage_post", rd_data, 8'h55);
        rd_sel = 1'b1; #1;
        check("blk_act_post", rd_data, 8'h11);
        rd_sel = 1'b0;

        // trigger held during COPY is accepted on the return-to-idle cycle
        do_write(8'hFF, 8'h01);
        do_write(8'hFF, 8'h01);
        check("retrig_busy", busy, 1);
        wait_idle();
        tick();
        check("retrig_act20", active[32*8 +: 8], 8'h55);

        // soft reset clear
        do_write(8'h02, 8'hA5);
        do_write(8'h00, 8'h20);
        cyc = 0; pulses = 0;
        while (busy && cyc < 1000) begin
            tick();
            cyc++;
            if (xfer_done) pulses++;
        end
        tick();
        if (xfer_done) pulses++;
        check("clear_cycles", cyc, 256);
        check("clear_pulses", pulses, 0);
        addr = 8'h02; #1;
        check("clear_dir02", rd_data, 8'h00);
        addr = 8'h00; #1;
        check("clear_srst", rd_data, 8'h00);
        addr = 8'h10; rd_sel = 1'b1; #1;
        check("clear_act10", rd_data, 8'h00);
        rd_sel = 1'b0;
        check("clear_active_all", 32'(active == '0), 1);

        // asynchronous reset in the middle of a copy
        do_write(8'h10, 8'h3C);
        do_write(8'hFF, 8'h01);
        repeat (49) tick();
        check("mid_busy_pre", busy, 1);
        reset_n = 1'b0; #1;
        check("mid_busy", busy, 0);
        check("mid_done", xfer_done, 0);
        check("mid_active", 32'(active == '0), 1);
        addr = 8'h10; #1;
        check("mid_rd", rd_data, 8'h00);
        tick();
        reset_n = 1'b1; #1;
        check("mid_ready", wr_ready, 1);
        tick();

        // single-entry buffered range: one-cycle copy
        s_addr = 4'h5; s_wr_data = 8'h77; s_wr_en = 1'b1;
        tick();
        s_addr = 4'hF; s_wr_data = 8'h01;
        tick();
        s_wr_en = 1'b0;
        check("s_busy", s_busy, 1);
        check("s_act5_pre", s_active[5*8 +: 8], 8'h00);
        tick();
        check("s_busy_post", s_busy, 0);
        check("s_done", s_xfer_done, 1);
        check("s_ready", s_wr_ready, 1);
        check("s_act5", s_active[5*8 +: 8], 8'h77);
        #1;
        check("s_xfer_bit", s_rd_data, 8'h00);
        s_addr = 4'h5; s_rd_sel = 1'b1; #1;
        check("s_rd_act5", s_rd_data, 8'h77);
        tick();
        check("s_done_once", s_xfer_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
